// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl -- Avalon-MM slave driving a multiplexed bank of
// seven-segment digits from one shared segment bus.
//
// Each digit is selected in turn for SCAN_DIV clk cycles. The digit
// shows either the hex decode of its VALUE nibble or its RAW pattern.
// A BLANK bit forces that digit's pattern dark. The digit strobe stays
// asserted while the digit is blanked.
//
// Register map (word address):
//   0 CTRL   bit0 EN, bit1 HEX (1 = decode nibble, 0 = raw pattern)
//   1 VALUE  nibble i = hex value of digit i
//   2 BLANK  bit i = 1 -> digit i dark
//   3 STATUS read-only; [2:0] scan index, [3] ghost-gap flag
//   4+i RAW  7-bit raw segment pattern of digit i
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   address, chipselect,
//   write_n, writedata  Avalon-MM write side (zero wait states)
//   readdata            combinational read data for current address
//   seg_out             segments a..g (bit0 = a); polarity set by ACTIVE_LOW
//   digit_sel           one-hot digit strobe; polarity set by ACTIVE_LOW
//
// Optional build macro SEVSEG_GHOST_GAP_EN: the last SCAN_DIV/8 cycles
// of each dwell (at least 1) drive every pin off. STATUS bit3 is 1 while
// the pins are in that gap. If the macro is not defined, no gap is
// inserted and STATUS bit3 reads 0.
`timescale 1ns/1ps

module sevseg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int                  PS_W     = $clog2(SCAN_DIV);
  localparam int                  VAL_W    = 4 * NUM_DIGITS;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [2:0]          IDX_LAST = 3'(NUM_DIGITS - 1);
  localparam bit                  POL_LOW  = (ACTIVE_LOW != 0);
  localparam logic [6:0]          SEG_OFF  = POL_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = POL_LOW ? '1 : '0;

  // Register file
  logic                  ctrl_en_reg;
  logic                  ctrl_hex_reg;
  logic [VAL_W-1:0]      value_reg;
  logic [NUM_DIGITS-1:0] blank_reg;
  logic [6:0]            raw_reg [NUM_DIGITS];

  // Scan engine
  logic [PS_W-1:0]       ps_reg;
  logic [2:0]            idx_reg;
  logic                  gap_now;

  // Output stage
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] dig_next;

  logic wr_en;
  assign wr_en = chipselect && !write_n;

  // Only the low bits of writedata are stored in any register.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    return p;
  endfunction

  // ---------------------------------------------------------------
  // Control, value and blank registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en_reg  <= 1'b0;
      ctrl_hex_reg <= 1'b0;
      value_reg    <= '0;
      blank_reg    <= '0;
    end else if (wr_en) begin
      case (address)
        4'd0: begin
          ctrl_en_reg  <= writedata[0];
          ctrl_hex_reg <= writedata[1];
        end
        4'd1:    value_reg <= writedata[VAL_W-1:0];
        4'd2:    blank_reg <= writedata[NUM_DIGITS-1:0];
        default: ;
      endcase
    end
  end

  // One raw-pattern register per digit at word address 4+gi
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_raw
      localparam logic [3:0] RAW_ADDR = 4'(4 + gi);
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          raw_reg[gi] <= 7'h00;
        else if (wr_en && address == RAW_ADDR)
          raw_reg[gi] <= writedata[6:0];
      end
    end
  endgenerate

  // ---------------------------------------------------------------
  // Prescaler and scan index. When the scan is disabled, both counters
  // are held at zero. This makes the next enable start at digit 0 with
  // a full dwell, and no separate edge detector is needed.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_reg  <= '0;
      idx_reg <= 3'd0;
    end else if (!ctrl_en_reg) begin
      ps_reg  <= '0;
      idx_reg <= 3'd0;
    end else if (ps_reg == PS_LAST) begin
      ps_reg  <= '0;
      idx_reg <= (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
    end else begin
      ps_reg  <= ps_reg + 1'b1;
    end
  end

`ifdef SEVSEG_GHOST_GAP_EN
  localparam int              GAP       = (SCAN_DIV / 8 < 1) ? 1 : SCAN_DIV / 8;
  localparam logic [PS_W-1:0] GAP_START = PS_W'(SCAN_DIV - GAP);

  // gap_reg follows the output registers, so STATUS bit3 marks the
  // cycles in which the pins are actually dark.
  logic gap_reg;
  assign gap_now = ctrl_en_reg && (ps_reg >= GAP_START);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      gap_reg <= 1'b0;
    else
      gap_reg <= gap_now;
  end
`else
  assign gap_now = 1'b0;
`endif

  // ---------------------------------------------------------------
  // Pattern selection for the current index. The outputs are computed
  // from the registered state only. If a register write and an index
  // advance land on the same edge, both show up together one cycle
  // later, so the display never mixes old and new values.
  // ---------------------------------------------------------------
  logic [3:0]            sel_nib;
  logic [6:0]            sel_raw;
  logic                  sel_blank;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic [6:0]            pattern;

  always_comb begin
    sel_nib    = 4'h0;
    sel_raw    = 7'h00;
    sel_blank  = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == 3'(i)) begin
        sel_nib       = value_reg[4*i +: 4];
        sel_raw       = raw_reg[i];
        sel_blank     = blank_reg[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pattern  = 7'h00;
    seg_next = SEG_OFF;
    dig_next = DIG_OFF;
    if (ctrl_en_reg && !gap_now) begin
      if (!sel_blank)
        pattern = ctrl_hex_reg ? hex_decode(sel_nib) : sel_raw;
      seg_next = POL_LOW ? ~pattern : pattern;
      dig_next = POL_LOW ? ~sel_onehot : sel_onehot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out   <= SEG_OFF;
      digit_sel <= DIG_OFF;
    end else begin
      seg_out   <= seg_next;
      digit_sel <= dig_next;
    end
  end

  // ---------------------------------------------------------------
  // Read mux: combinational, zero-extended; unmapped addresses read 0
  // ---------------------------------------------------------------
  always_comb begin
    readdata = 32'h0;
    case (address)
      4'd0: readdata[1:0] = {ctrl_hex_reg, ctrl_en_reg};
      4'd1: readdata[VAL_W-1:0] = value_reg;
      4'd2: readdata[NUM_DIGITS-1:0] = blank_reg;
      4'd3: begin
        readdata[2:0] = idx_reg;
`ifdef SEVSEG_GHOST_GAP_EN
        readdata[3] = gap_reg;
`endif
      end
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (address == 4'(4 + i))
            readdata[6:0] = raw_reg[i];
      end
    endcase
  end

endmodule
